// File: rtl/mem_wb_stage.sv
// M/W pipeline boundary: load-data formatting, W-stage registers, retired-instruction counter.
// Optional misaligned-load detection is enabled with `define MISALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [4:0]       RdM,
  input  logic [2:0]       Funct3M,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  RawReadDataM,
  input  logic [XLEN-1:0]  PCPlus4M,
  output logic             ValidW,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [4:0]       RdW,
  output logic [XLEN-1:0]  ALUResultW,
  output logic [XLEN-1:0]  ReadDataW,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [CNT_W-1:0] InstRetW,
  output logic             MisalignW
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [1:0]       addr_lo;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_data_c;
  logic             misalign_c;
  logic             load_en_c;
  logic [CNT_W-1:0] inst_ret_nxt_c;

  assign addr_lo = ALUResultM[1:0];

  // Byte/half lane select, little-endian
  always_comb begin
    ld_byte = RawReadDataM[7:0];
    ld_half = RawReadDataM[15:0];
    case (addr_lo)
      2'b00: ld_byte = RawReadDataM[7:0];
      2'b01: ld_byte = RawReadDataM[15:8];
      2'b10: ld_byte = RawReadDataM[23:16];
      2'b11: ld_byte = RawReadDataM[31:24];
      default: ld_byte = RawReadDataM[7:0];
    endcase
    if (addr_lo[1]) ld_half = RawReadDataM[31:16];
  end

  // Sign/zero extension by load type; unknown types pass the word through
  always_comb begin
    ld_data_c = RawReadDataM;
    case (Funct3M)
      F3_LB:   ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data_c = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LH:   ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LHU:  ld_data_c = {{(XLEN-16){1'b0}}, ld_half};
      F3_LW:   ld_data_c = RawReadDataM;
      default: ld_data_c = RawReadDataM;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    if (ValidM && (ResultSrcM == 2'b01)) begin
      if (((Funct3M == F3_LH) || (Funct3M == F3_LHU)) && addr_lo[0]) misalign_c = 1'b1;
      if ((Funct3M == F3_LW) && (addr_lo != 2'b00))                  misalign_c = 1'b1;
    end
  end
`else
  assign misalign_c = 1'b0;
`endif

  assign load_en_c = !FlushW && !StallW;

  // Counter update is written every edge so that a hold is an explicit re-write
  assign inst_ret_nxt_c = InstRetW + CNT_W'(load_en_c && ValidM);

  // W-stage pipeline registers: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset || FlushW) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
    end else if (!StallW) begin
      ValidW     <= ValidM;
      RegWriteW  <= RegWriteM && ValidM && !misalign_c;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= ld_data_c;
      PCPlus4W   <= PCPlus4M;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) InstRetW <= '0;
    else       InstRetW <= inst_ret_nxt_c;
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || FlushW) MisalignW <= 1'b0;
    else if (!StallW)    MisalignW <= misalign_c;
  end
`else
  assign MisalignW = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-cycle expected W state queued at drive, compared after the edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, RawReadDataM, PCPlus4M;
  logic        ValidW, RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, InstRetW;

  typedef struct packed {
    logic        valid;
    logic        regw;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        mis;
  } wstate_t;

  wstate_t model;
  wstate_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .RawReadDataM(RawReadDataM), .PCPlus4M(PCPlus4M),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .InstRetW(InstRetW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] raw);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = raw >> (addr[1:0] * 8);
    b  = sh[7:0];
    h  = addr[1] ? raw[31:16] : raw[15:0];
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return {24'd0, b};
      3'b001:  return 32'($signed(h));
      3'b101:  return {16'd0, h};
      default: return raw;
    endcase
  endfunction

  function automatic logic is_misaligned();
`ifdef MISALIGN_CHECK_EN
    if (!ValidM || ResultSrcM != 2'b01) return 1'b0;
    if ((Funct3M == 3'b001 || Funct3M == 3'b101) && ALUResultM[0]) return 1'b1;
    if (Funct3M == 3'b010 && ALUResultM[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Advance the model with the current inputs, queue the prediction, clock, then compare
  task automatic tick();
    wstate_t got, exp;
    logic m;
    m = is_misaligned();
    if (reset) begin
      model = '0;
    end else if (FlushW) begin
      model = '{valid: 1'b0, regw: 1'b0, rsrc: 2'b00, rd: 5'd0, alu: 32'd0, rdata: 32'd0,
                pc4: 32'd0, cnt: model.cnt, mis: 1'b0};
    end else if (!StallW) begin
      model.valid = ValidM;
      model.regw  = RegWriteM & ValidM & ~m;
      model.rsrc  = ResultSrcM;
      model.rd    = RdM;
      model.alu   = ALUResultM;
      model.rdata = fmt_load(Funct3M, ALUResultM, RawReadDataM);
      model.pc4   = PCPlus4M;
      model.mis   = m;
      if (ValidM) model.cnt = model.cnt + 32'd1;
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = '{valid: ValidW, regw: RegWriteW, rsrc: ResultSrcW, rd: RdW, alu: ALUResultW,
            rdata: ReadDataW, pc4: PCPlus4W, cnt: InstRetW, mis: MisalignW};
    check("ValidW",     32'(got.valid), 32'(exp.valid));
    check("RegWriteW",  32'(got.regw),  32'(exp.regw));
    check("ResultSrcW", 32'(got.rsrc),  32'(exp.rsrc));
    check("RdW",        32'(got.rd),    32'(exp.rd));
    check("ALUResultW", got.alu,   exp.alu);
    check("ReadDataW",  got.rdata, exp.rdata);
    check("PCPlus4W",   got.pc4,   exp.pc4);
    check("InstRetW",   got.cnt,   exp.cnt);
    check("MisalignW",  32'(got.mis), 32'(exp.mis));
  endtask

  task automatic randomize_m();
    ValidM       = 1'($urandom);
    RegWriteM    = 1'($urandom);
    ResultSrcM   = 2'($urandom_range(0, 2));
    RdM          = 5'($urandom);
    Funct3M      = 3'($urandom);
    ALUResultM   = $urandom;
    RawReadDataM = $urandom;
    PCPlus4M     = $urandom;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw);
    ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 2'b01; RdM = 5'd7;
    Funct3M = f3; ALUResultM = addr; RawReadDataM = raw; PCPlus4M = 32'h0000_1004;
  endtask

  initial begin
    logic [31:0] held_cnt;
    model = '0;
    reset = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    randomize_m();
    @(negedge clk);

    // Reset with random inputs, including stall/flush asserted
    tick();
    randomize_m(); StallW = 1'b1; FlushW = 1'b1;
    tick();
    check("reset_cnt", InstRetW, 32'd0);
    reset = 1'b0; StallW = 1'b0; FlushW = 1'b0;

    // Directed load-format cases
    set_load(3'b000, 32'h0000_2003, 32'h80FF_1234); tick(); check("lb_a3",  ReadDataW, 32'hFFFF_FF80);
    set_load(3'b100, 32'h0000_2003, 32'h80FF_1234); tick(); check("lbu_a3", ReadDataW, 32'h0000_0080);
    set_load(3'b001, 32'h0000_2002, 32'h8001_7FFF); tick(); check("lh_a2",  ReadDataW, 32'hFFFF_8001);
    set_load(3'b101, 32'h0000_2002, 32'h8001_7FFF); tick(); check("lhu_a2", ReadDataW, 32'h0000_8001);
    set_load(3'b001, 32'h0000_2000, 32'h8001_7FFF); tick(); check("lh_a0",  ReadDataW, 32'h0000_7FFF);
    set_load(3'b000, 32'h0000_2001, 32'h80FF_1234); tick(); check("lb_a1",  ReadDataW, 32'h0000_0012);
    set_load(3'b111, 32'h0000_2003, 32'hDEAD_BEEF); tick(); check("f3_other", ReadDataW, 32'hDEAD_BEEF);

    // Random normal traffic
    for (int i = 0; i < 24; i++) begin
      randomize_m();
      tick();
    end

    // Stall holds, then flush overrides stall
    set_load(3'b010, 32'h0000_3000, 32'h1234_5678); RdM = 5'd5; tick();
    held_cnt = InstRetW;
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_m(); ValidM = 1'b1;
      tick();
      check("stall_rd", 32'(RdW), 32'd5);
    end
    FlushW = 1'b1; tick();
    check("flush_valid", 32'(ValidW), 32'd0);
    check("flush_cnt", InstRetW, held_cnt);
    StallW = 1'b0; FlushW = 1'b0;

    // Counter: 10 valid instructions among a bubble and a flushed slot
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      randomize_m();
      ValidM = (i != 4);
      FlushW = (i == 8);
      tick();
    end
    FlushW = 1'b0;
    check("cnt_ten", InstRetW, 32'd10);

    // Counter wrap from all-ones
    randomize_m(); StallW = 1'b1;
    force dut.InstRetW = 32'hFFFF_FFFF;
    model.cnt = 32'hFFFF_FFFF;
    tick();
    release dut.InstRetW;
    StallW = 1'b0; ValidM = 1'b1; tick();
    check("cnt_wrap", InstRetW, 32'd0);

    // Misaligned word load
    set_load(3'b010, 32'h0000_4001, 32'hCAFE_F00D); tick();
`ifdef MISALIGN_CHECK_EN
    check("mis_flag", 32'(MisalignW), 32'd1);
    check("mis_regw", 32'(RegWriteW), 32'd0);
`else
    check("mis_flag", 32'(MisalignW), 32'd0);
    check("mis_regw", 32'(RegWriteW), 32'd1);
`endif
    check("mis_cnt", InstRetW, 32'd1);
    set_load(3'b101, 32'h0000_4003, 32'hCAFE_F00D); tick();
    set_load(3'b001, 32'h0000_4002, 32'hCAFE_F00D); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
